keypad_operand_entry: RTL and testbench
=======================================

// Module: keypad_operand_entry
// PURPOSE
//  Multi-operand hex entry stage between keypad_base (value/valid strobes) and the FP adder.
//  - Collects NUM_OPS operands of DIGITS hex nibbles each, with digit limit, backspace and enter.
//  - Presents the complete operand set on a valid/ready handshake.
//  - Successor to the single shift-register keypad input: adds editing, operand sequencing and flow control.
// PARAMETERS
//  DIGITS   4  hex nibbles per operand (operand width W = 4*DIGITS)
//  NUM_OPS  2  operands per entry set (>=1); IDXW = max(1,$clog2(NUM_OPS))
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  reset      in   1           asynchronous, active-high reset
//  key_value  in   4           hex digit from keypad_base, sampled when key_valid=1
//  key_valid  in   1           single-cycle digit strobe
//  enter      in   1           single-cycle strobe: commit current operand
//  bksp       in   1           single-cycle strobe: delete last digit
//  ops_out    out  NUM_OPS*W   operand k at [k*W +: W]; operand 0 entered first
//  ops_valid  out  1           operand set complete and stable
//  ops_ready  in   1           consumer accepts set when ops_valid & ops_ready
//  cur_value  out  W           operand being edited (for display); 0 in HOLD
//  cur_index  out  IDXW        index of operand being edited
//  digit_cnt  out  $clog2(DIGITS+1)  digits in current operand
// BEHAVIOUR
//  Reset (async): state=ENTRY, ops_out=0, cur_value=0, cur_index=0, digit_cnt=0, ops_valid=0.
//  States: ENTRY (editing), HOLD (set presented).
//  ENTRY, one action per cycle, priority enter > bksp > key_valid; lower-priority strobes in the same cycle are dropped.
//   - key_valid: if digit_cnt<DIGITS, cur_value <= {cur_value[W-5:0],key_value}, digit_cnt+1.
//     If digit_cnt==DIGITS, behaviour is set by KEYPAD_OVERWRITE_EN.
//   - bksp: if digit_cnt>0, cur_value <= cur_value>>4, digit_cnt-1; at 0 no-op.
//   - enter, digit_cnt==0 allowed (commits 0):
//     - ops_out[cur_index] <= cur_value; cur_value<=0; digit_cnt<=0.
//     - if cur_index<NUM_OPS-1: cur_index+1; else cur_index<=0, go HOLD, ops_valid<=1.
//   - Latency: strobe in cycle N -> registers/outputs updated at edge ending N (visible N+1).
//  HOLD:
//   - ops_valid=1; ops_out stable; key_valid/enter/bksp ignored.
//   - ops_valid&ops_ready at edge -> ops_out<=0, ops_valid<=0, state ENTRY.
//     Strobes in that same cycle are dropped.
//  Handshake: ops_valid never drops without ready; ops_ready while ops_valid=0 has no effect.
//  Reset mid-entry or in HOLD: all state cleared immediately, any partial set is discarded.
//  No combinational path from inputs to outputs; all outputs registered.
// CONFIGURATION
//  KEYPAD_OVERWRITE_EN
//   defined: digit at digit_cnt==DIGITS shifts in, oldest nibble falls off MSB; digit_cnt stays DIGITS.
//   undefined: digit at digit_cnt==DIGITS is ignored; cur_value, digit_cnt unchanged.
// TESTING
//  1 reset; keys 3,C,0,0, enter; keys 4,1,0,0, enter -> ops_valid=1, ops_out=32'h4100_3C00, cur_index=0.
//  2 keys 1,2,3,4,5 (no macro) -> cur_value=16'h1234, digit_cnt=4;
//    (KEYPAD_OVERWRITE_EN) -> 16'h2345, digit_cnt=4.
//  3 keys A,B, bksp, bksp, bksp -> cur_value 00AB->000A->0000, digit_cnt 2->1->0->0; then enter -> operand 0 = 0.
//  4 in HOLD with ops_ready=0 for 10 cycles, keys/enter pulsed -> ops_out/ops_valid unchanged;
//    ops_ready=1 -> next cycle ops_valid=0, ops_out=0.
//  5 enter+bksp+key_valid in same cycle with cur_value=0012 -> only commit occurs:
//    operand=0012, cur_value=0, digit_cnt=0.
//  6 assert reset after 3 digits of operand 1 -> all outputs 0, cur_index=0, state ENTRY next cycle.

Source files
------------

// File: rtl/keypad_operand_entry.sv
// Multi-operand hex entry stage: collects NUM_OPS operands of DIGITS nibbles and presents them on valid/ready.
// Define KEYPAD_OVERWRITE_EN to shift digits through a full operand instead of ignoring them.
module keypad_operand_entry #(
  parameter int DIGITS  = 4,
  parameter int NUM_OPS = 2,
  localparam int W      = 4 * DIGITS,
  localparam int IDXW   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [3:0]           key_value_i,
  input  logic                 key_valid_i,
  input  logic                 enter_i,
  input  logic                 bksp_i,
  output logic [NUM_OPS*W-1:0] ops_o,
  output logic                 ops_valid_o,
  input  logic                 ops_ready_i,
  output logic [W-1:0]         cur_value_o,
  output logic [IDXW-1:0]      cur_index_o,
  output logic [CW-1:0]        digit_cnt_o
);

  // state    | meaning
  // ST_ENTRY | editing operand cur_index, strobes accepted
  // ST_HOLD  | full set presented, waiting for ops_ready
  typedef enum logic {ST_ENTRY, ST_HOLD} state_t;

  localparam logic [CW-1:0]   FULL_CNT = CW'(DIGITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OPS - 1);

  state_t                       state_q, state_d;
  logic [NUM_OPS-1:0][W-1:0]    ops_q, ops_d;
  logic                         ops_valid_q, ops_valid_d;
  logic [W-1:0]                 cur_value_q, cur_value_d;
  logic [IDXW-1:0]              cur_index_q, cur_index_d;
  logic [CW-1:0]                digit_cnt_q, digit_cnt_d;
  logic [W-1:0]                 shifted_in;

  // Truncating the concatenation drops the oldest nibble; also valid when DIGITS==1.
  assign shifted_in = W'({cur_value_q, key_value_i});

  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    ops_valid_d = ops_valid_q;
    cur_value_d = cur_value_q;
    cur_index_d = cur_index_q;
    digit_cnt_d = digit_cnt_q;
    case (state_q)
      ST_ENTRY: begin
        if (enter_i) begin
          ops_d[cur_index_q] = cur_value_q;
          cur_value_d        = '0;
          digit_cnt_d        = '0;
          if (cur_index_q == LAST_IDX) begin
            cur_index_d = '0;
            state_d     = ST_HOLD;
            ops_valid_d = 1'b1;
          end else begin
            cur_index_d = cur_index_q + 1'b1;
          end
        end else if (bksp_i) begin
          if (digit_cnt_q != '0) begin
            cur_value_d = cur_value_q >> 4;
            digit_cnt_d = digit_cnt_q - 1'b1;
          end
        end else if (key_valid_i) begin
          if (digit_cnt_q < FULL_CNT) begin
            cur_value_d = shifted_in;
            digit_cnt_d = digit_cnt_q + 1'b1;
          end else begin
`ifdef KEYPAD_OVERWRITE_EN
            cur_value_d = shifted_in;
`else
            cur_value_d = cur_value_q;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (ops_ready_i) begin
          ops_d       = '0;
          ops_valid_d = 1'b0;
          state_d     = ST_ENTRY;
        end
      end
      default: begin
        state_d     = ST_ENTRY;
        ops_d       = '0;
        ops_valid_d = 1'b0;
        cur_value_d = '0;
        cur_index_d = '0;
        digit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_ENTRY;
      ops_q       <= '0;
      ops_valid_q <= 1'b0;
      cur_value_q <= '0;
      cur_index_q <= '0;
      digit_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ops_q       <= ops_d;
      ops_valid_q <= ops_valid_d;
      cur_value_q <= cur_value_d;
      cur_index_q <= cur_index_d;
      digit_cnt_q <= digit_cnt_d;
    end
  end

  assign ops_o       = ops_q;
  assign ops_valid_o = ops_valid_q;
  assign cur_value_o = cur_value_q;
  assign cur_index_o = cur_index_q;
  assign digit_cnt_o = digit_cnt_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Randomized bench for keypad_operand_entry against a digit-list reference model.
module tb_keypad_operand_entry;
  localparam int D = 4;
  localparam int N = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  key_value_i = '0;
  logic        key_valid_i = 1'b0, enter_i = 1'b0, bksp_i = 1'b0, ops_ready_i = 1'b0;
  logic [31:0] ops_o;
  logic        ops_valid_o;
  logic [15:0] cur_value_o;
  logic [0:0]  cur_index_o;
  logic [2:0]  digit_cnt_o;

  keypad_operand_entry #(.DIGITS(D), .NUM_OPS(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .key_value_i(key_value_i), .key_valid_i(key_valid_i),
    .enter_i(enter_i), .bksp_i(bksp_i), .ops_o(ops_o), .ops_valid_o(ops_valid_o),
    .ops_ready_i(ops_ready_i), .cur_value_o(cur_value_o), .cur_index_o(cur_index_o),
    .digit_cnt_o(digit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: digits of the current operand as a list, committed operands as an array.
  int          digs[$];
  logic [15:0] mops[N];
  int          midx;
  bit          mhold;

  function automatic logic [15:0] mcur();
    int v = 0;
    foreach (digs[i]) v = v * 16 + digs[i];
    return 16'(v);
  endfunction

  function automatic logic [31:0] mpacked();
    logic [31:0] r = '0;
    for (int k = 0; k < N; k++) r = r | (32'(mops[k]) << (k * 16));
    return r;
  endfunction

  task automatic model_reset();
    digs.delete();
    for (int k = 0; k < N; k++) mops[k] = '0;
    midx = 0;
    mhold = 0;
  endtask

  task automatic model_step(input bit kv, input int kval, input bit en, input bit bk, input bit rdy);
    if (mhold) begin
      if (rdy) begin
        mhold = 0;
        for (int k = 0; k < N; k++) mops[k] = '0;
      end
    end else if (en) begin
      mops[midx] = mcur();
      digs.delete();
      if (midx == N - 1) begin
        midx = 0;
        mhold = 1;
      end else midx++;
    end else if (bk) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (kv) begin
      if (digs.size() < D) digs.push_back(kval);
      else begin
`ifdef KEYPAD_OVERWRITE_EN
        void'(digs.pop_front());
        digs.push_back(kval);
`endif
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".ops"}, 64'(ops_o), 64'(mpacked()));
    chk({tag, ".valid"}, 64'(ops_valid_o), 64'(mhold));
    chk({tag, ".cur"}, 64'(cur_value_o), 64'(mcur()));
    chk({tag, ".idx"}, 64'(cur_index_o), 64'(midx));
    chk({tag, ".cnt"}, 64'(digit_cnt_o), 64'(digs.size()));
  endtask

  task automatic step(input string tag, input bit kv, input int kval, input bit en,
                      input bit bk, input bit rdy);
    key_valid_i = kv; key_value_i = 4'(kval); enter_i = en; bksp_i = bk; ops_ready_i = rdy;
    @(posedge clk_i);
    model_step(kv, kval, en, bk, rdy);
    #1;
    compare_all(tag);
    key_valid_i = 0; enter_i = 0; bksp_i = 0; ops_ready_i = 0;
  endtask

  task automatic key(input string tag, input int v);
    step(tag, 1, v, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1;
    #2;
    model_reset();
    compare_all(tag);
    reset_i = 0;
  endtask

  initial begin
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk_i);
    reset_i = 0;

    // Two full operands -> HOLD
    key("t1", 3); key("t1", 12); key("t1", 0); key("t1", 0); step("t1", 0, 0, 1, 0, 0);
    key("t1", 4); key("t1", 1); key("t1", 0); key("t1", 0); step("t1", 0, 0, 1, 0, 0);
    chk("t1.set", 64'(ops_o), 64'h4100_3C00);
    chk("t1.valid", 64'(ops_valid_o), 64'd1);

    // HOLD ignores strobes while ready is low
    for (int i = 0; i < 10; i++)
      step("t4", $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1), 0);
    chk("t4.hold", 64'(ops_o), 64'h4100_3C00);
    step("t4", 1, 7, 1, 0, 1);
    chk("t4.rel_valid", 64'(ops_valid_o), 64'd0);
    chk("t4.rel_ops", 64'(ops_o), 64'd0);
    chk("t4.rel_cur", 64'(cur_value_o), 64'd0);

    // Fifth digit on a full operand
    key("t2", 1); key("t2", 2); key("t2", 3); key("t2", 4); key("t2", 5);
`ifdef KEYPAD_OVERWRITE_EN
    chk("t2.cur", 64'(cur_value_o), 64'h2345);
`else
    chk("t2.cur", 64'(cur_value_o), 64'h1234);
`endif
    chk("t2.cnt", 64'(digit_cnt_o), 64'd4);
    step("t2", 0, 0, 1, 0, 0);

    // Backspace down to empty, then commit zero as operand 1
    key("t3", 10); key("t3", 11);
    chk("t3.ab", 64'(cur_value_o), 64'h00AB);
    step("t3", 0, 0, 0, 1, 0);
    chk("t3.a", 64'(cur_value_o), 64'h000A);
    chk("t3.cnt1", 64'(digit_cnt_o), 64'd1);
    step("t3", 0, 0, 0, 1, 0);
    step("t3", 0, 0, 0, 1, 0);
    chk("t3.cnt0", 64'(digit_cnt_o), 64'd0);
    step("t3", 0, 0, 1, 0, 0);
    chk("t3.op1", 64'(ops_o[31:16]), 64'd0);
    chk("t3.valid", 64'(ops_valid_o), 64'd1);
    step("t3", 0, 0, 0, 0, 1);

    // Simultaneous strobes: only the commit takes effect
    key("t5", 1); key("t5", 2);
    step("t5", 1, 9, 1, 1, 0);
    chk("t5.op0", 64'(ops_o[15:0]), 64'h0012);
    chk("t5.cur", 64'(cur_value_o), 64'd0);
    chk("t5.cnt", 64'(digit_cnt_o), 64'd0);

    // Reset mid-entry of operand 1
    key("t6", 5); key("t6", 6); key("t6", 7);
    do_reset("t6.rst");
    chk("t6.ops", 64'(ops_o), 64'd0);
    key("t6.after", 8);

    // Random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset("rnd.rst");
      else
        step("rnd", $urandom_range(0, 99) < 55, $urandom_range(0, 15), $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
